spi_transaction_fsm: RTL and testbench
======================================

Name: spi_transaction_fsm

Overview:
Transaction controller for the SPI memory slave. It consumes the conditioned chip-select and the single-cycle SCLK edge pulses produced by the input conditioners, counts protocol bits, and sequences the shared datapath: address latch write, data-memory write, shift-register parallel load and MISO tri-state buffer enable. Each transaction carries an address phase (address bits plus one R/W bit, MSB first) followed by a data phase.

Parameters:
addrwidth, 7, address bits per transaction; the R/W bit follows them.
datawidth, 8, data bits per transaction.
countwidth, 4, bit-counter width; must be >= clog2(max(addrwidth+1, datawidth)+1).

Ports:
clk  input  1  system clock; all logic on its rising edge
reset_n  input  1  synchronous active-low reset
cs_n  input  1  conditioned chip select, active low
sclk_posedge  input  1  one-clk pulse on each conditioned SCLK rising edge
sclk_negedge  input  1  one-clk pulse on each conditioned SCLK falling edge
rw_bit  input  1  shift-register parallel-out bit 0 (last bit shifted in); 1 = read, 0 = write
addr_we  output  1  address latch write enable
dm_we  output  1  data memory write enable
sr_we  output  1  shift-register parallel-load enable
miso_buff  output  1  MISO tri-state buffer enable
busy  output  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (reset_n): sampled only on the rising edge of clk, and when low forces IDLE with the counter at 0.
- State and outputs: state register and bit counter are clocked. Outputs are Moore, decoded from the current state only. All outputs are 0 in IDLE, so all outputs are 0 in the cycle after reset_n is sampled low.
- IDLE: counter = 0. If cs_n == 0, go to GET_ADDR.
- GET_ADDR: each sclk_posedge increments the counter. On the sclk_posedge where counter == addrwidth (the addrwidth+1-th edge), clear the counter and go to ADDR_LATCH. sclk_negedge is ignored.
- ADDR_LATCH (1 cycle): addr_we = 1. If rw_bit == 1, go to READ_WAIT; otherwise go to WRITE_GET. rw_bit is valid here because the shift register updated on the previous posedge.
- READ_WAIT (1 cycle): all outputs 0. This absorbs the one-cycle memory read latency. Next state is READ_LOAD.
- READ_LOAD (1 cycle): sr_we = 1. Next state is READ_SHIFT.
- READ_SHIFT: miso_buff = 1. Each sclk_negedge increments the counter. On the negedge where counter == datawidth-1, clear the counter and go to DONE. sclk_posedge is ignored.
- WRITE_GET: each sclk_posedge increments the counter. On the posedge where counter == datawidth-1, clear the counter and go to WRITE_STORE.
- WRITE_STORE (1 cycle): dm_we = 1. Next state is DONE.
- DONE: all outputs 0 except busy. All SCLK edges are ignored. Stay here until cs_n == 1.
- Chip-select deassertion: cs_n == 1 in any non-IDLE state goes to IDLE next cycle with the counter cleared. This overrides any simultaneous sclk pulse or counter terminal condition; an aborted write never produces dm_we.
- Reset priority: reset_n == 0 overrides everything, including cs_n, mid-transaction.
- Simultaneous pulses: sclk_posedge and sclk_negedge in the same cycle are each handled only by the state that uses them; the other is ignored.
- Counter: the counter never wraps; it is cleared at every phase transition.
- Pulse widths: addr_we, sr_we and dm_we are each high for exactly one clk cycle per transaction.

Test Plan:
- Read: cs_n = 0; 8 posedges (7 address bits, then rw_bit = 1) -> addr_we one cycle later; sr_we exactly 2 cycles after addr_we; miso_buff high from the next cycle through the 8th negedge; DONE; cs_n = 1 -> IDLE, busy = 0.
- Write: cs_n = 0; 8 posedges with rw_bit = 0 -> addr_we one cycle; then 8 posedges -> dm_we high exactly one cycle after the 8th; sr_we and miso_buff never asserted.
- Abort: cs_n = 1 after 5 address posedges -> IDLE next cycle, addr_we never asserted. Next transaction again needs the full 8 address edges.
- Reset mid-write: reset_n = 0 after 4 data posedges -> all outputs 0 and busy = 0 next cycle, no dm_we. A full write afterwards succeeds.
- Edge filtering: negedges during GET_ADDR and WRITE_GET, and posedges during READ_SHIFT, do not advance the counter. Extra edges in DONE produce no output pulses.
- Simultaneous events: cs_n = 1 in the same cycle as the 8th data posedge of a write -> IDLE, dm_we stays 0.

Source files
------------

// File: rtl/spi_transaction_fsm.sv
// Sequencer for the SPI memory slave: counts address/data bits from conditioned
// SCLK edge pulses and drives the latch, memory, shift-register and MISO enables.
module spi_transaction_fsm #(
   parameter int addrwidth  = 7,
   parameter int datawidth  = 8,
   parameter int countwidth = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic cs_n,
   input  logic sclk_posedge,
   input  logic sclk_negedge,
   input  logic rw_bit,
   output logic addr_we,
   output logic dm_we,
   output logic sr_we,
   output logic miso_buff,
   output logic busy
);

   localparam logic [3:0] IDLE        = 4'd0;
   localparam logic [3:0] GET_ADDR    = 4'd1;
   localparam logic [3:0] ADDR_LATCH  = 4'd2;
   localparam logic [3:0] READ_WAIT   = 4'd3;
   localparam logic [3:0] READ_LOAD   = 4'd4;
   localparam logic [3:0] READ_SHIFT  = 4'd5;
   localparam logic [3:0] WRITE_GET   = 4'd6;
   localparam logic [3:0] WRITE_STORE = 4'd7;
   localparam logic [3:0] DONE        = 4'd8;

   // Terminal counts: address phase includes the trailing R/W bit.
   localparam logic [countwidth-1:0] addr_last = countwidth'(addrwidth);
   localparam logic [countwidth-1:0] data_last = countwidth'(datawidth - 1);

   logic [3:0]            state_reg, state_next;
   logic [countwidth-1:0] count_reg, count_next;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      // Chip-select release wins over any edge or terminal count this cycle.
      if (state_reg != IDLE && cs_n) begin
         state_next = IDLE;
         count_next = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               count_next = '0;
               if (!cs_n) state_next = GET_ADDR;
            end
            GET_ADDR: begin
               if (sclk_posedge) begin
                  if (count_reg == addr_last) begin
                     count_next = '0;
                     state_next = ADDR_LATCH;
                  end else begin
                     count_next = count_reg + 1'b1;
                  end
               end
            end
            ADDR_LATCH: state_next = rw_bit ? READ_WAIT : WRITE_GET;
            READ_WAIT:  state_next = READ_LOAD;
            READ_LOAD:  state_next = READ_SHIFT;
            READ_SHIFT: begin
               if (sclk_negedge) begin
                  if (count_reg == data_last) begin
                     count_next = '0;
                     state_next = DONE;
                  end else begin
                     count_next = count_reg + 1'b1;
                  end
               end
            end
            WRITE_GET: begin
               if (sclk_posedge) begin
                  if (count_reg == data_last) begin
                     count_next = '0;
                     state_next = WRITE_STORE;
                  end else begin
                     count_next = count_reg + 1'b1;
                  end
               end
            end
            WRITE_STORE: state_next = DONE;
            DONE:        state_next = DONE;
            default: begin
               state_next = IDLE;
               count_next = '0;
            end
         endcase
      end
   end

   assign addr_we   = (state_reg == ADDR_LATCH);
   assign sr_we     = (state_reg == READ_LOAD);
   assign dm_we     = (state_reg == WRITE_STORE);
   assign miso_buff = (state_reg == READ_SHIFT);
   assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_transaction_fsm.sv
// Randomized scoreboard bench for spi_transaction_fsm: transaction-level stimulus
// predicts output events by edge counting; a monitor checks every cycle.
module tb_spi_transaction_fsm;

   localparam int AW = 7;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic reset_n, cs_n, sclk_posedge, sclk_negedge, rw_bit;
   logic addr_we, dm_we, sr_we, miso_buff, busy;

   spi_transaction_fsm #(.addrwidth(AW), .datawidth(DW), .countwidth(4)) dut (
      .clk(clk), .reset_n(reset_n), .cs_n(cs_n),
      .sclk_posedge(sclk_posedge), .sclk_negedge(sclk_negedge), .rw_bit(rw_bit),
      .addr_we(addr_we), .dm_we(dm_we), .sr_we(sr_we),
      .miso_buff(miso_buff), .busy(busy)
   );

   always #5 clk = ~clk;

   // kind: 0 addr_we, 1 sr_we, 2 dm_we, 3 miso_buff; cyc = posedge after which it is visible
   typedef struct {
      int cyc;
      int kind;
   } ev_t;

   ev_t  sb[$];
   int   pos_cnt = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic exp_busy = 1'b0;

   // Monitor: one expected output per cycle at most, since outputs are mutually exclusive.
   always @(posedge clk) begin
      int   exp_kind;
      logic [3:0] outv;
      string names [4];
      pos_cnt++;
      #1;
      names[0] = "addr_we"; names[1] = "sr_we"; names[2] = "dm_we"; names[3] = "miso_buff";
      n_cmp++;
      if (busy !== exp_busy) begin
         n_bad++;
         $display("FAIL busy cycle %0d: got %b required %b", pos_cnt, busy, exp_busy);
      end
      exp_kind = -1;
      if (sb.size() > 0 && sb[0].cyc == pos_cnt) begin
         exp_kind = sb[0].kind;
         void'(sb.pop_front());
      end
      outv = {miso_buff, dm_we, sr_we, addr_we};
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (outv[k] !== (exp_kind == k)) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %b required %b", names[k], pos_cnt, outv[k], (exp_kind == k));
         end
      end
   end

   function automatic logic rb(input int pct);
      return ($urandom_range(99) < pct);
   endfunction

   // One clock of stimulus; ev is the output expected right after this cycle's posedge.
   task automatic step(input logic cs, input logic pe, input logic ne, input logic rst, input int ev);
      ev_t e;
      cs_n = cs;
      sclk_posedge = pe;
      sclk_negedge = ne;
      reset_n = rst;
      exp_busy = rst & ~cs;
      if (ev >= 0) begin
         e.cyc = pos_cnt + 1;
         e.kind = ev;
         sb.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic gaps(input logic noisy, input logic allow_pe, input logic allow_ne, input int ev);
      int n;
      n = noisy ? int'($urandom_range(2)) : 0;
      for (int i = 0; i < n; i++)
         step(1'b0, allow_pe & rb(50), allow_ne & rb(50), 1'b1, ev);
   endtask

   task automatic abort(input logic by_reset, input logic pe, input logic ne);
      if (by_reset) step(rb(50), pe, ne, 1'b0, -1);
      else          step(1'b1, pe, ne, 1'b1, -1);
      step(1'b1, 1'b0, 1'b0, 1'b1, -1);
   endtask

   // ab_phase: 0 none, 1 address phase, 2 data phase; ab_edge: edge index (1-based) replaced by the abort
   task automatic do_txn(input logic rd, input int ab_phase, input int ab_edge, input logic ab_rst,
                         input logic noisy);
      rw_bit = rd;
      step(1'b0, 1'b0, 1'b0, 1'b1, -1);
      for (int k = 1; k <= AW + 1; k++) begin
         gaps(noisy, 1'b0, 1'b1, -1);
         if (ab_phase == 1 && ab_edge == k) begin
            abort(ab_rst, 1'b1, 1'b0);
            return;
         end
         step(1'b0, 1'b1, noisy & rb(30), 1'b1, (k == AW + 1) ? 0 : -1);
      end
      if (rd) begin
         step(1'b0, noisy & rb(50), noisy & rb(50), 1'b1, -1);
         step(1'b0, noisy & rb(50), noisy & rb(50), 1'b1, 1);
         step(1'b0, noisy & rb(50), noisy & rb(50), 1'b1, 3);
         for (int k = 1; k <= DW; k++) begin
            gaps(noisy, 1'b1, 1'b0, 3);
            if (ab_phase == 2 && ab_edge == k) begin
               abort(ab_rst, 1'b0, 1'b1);
               return;
            end
            step(1'b0, noisy & rb(30), 1'b1, 1'b1, (k < DW) ? 3 : -1);
         end
      end else begin
         step(1'b0, noisy & rb(50), noisy & rb(50), 1'b1, -1);
         for (int k = 1; k <= DW; k++) begin
            gaps(noisy, 1'b0, 1'b1, -1);
            if (ab_phase == 2 && ab_edge == k) begin
               abort(ab_rst, 1'b1, 1'b0);
               return;
            end
            step(1'b0, 1'b1, noisy & rb(30), 1'b1, (k == DW) ? 2 : -1);
         end
      end
      // DONE: any edges must be ignored
      repeat ($urandom_range(3)) step(1'b0, rb(50), rb(50), 1'b1, -1);
      step(1'b1, 1'b0, 1'b0, 1'b1, -1);
      repeat ($urandom_range(1)) step(1'b1, rb(50), rb(50), 1'b1, -1);
   endtask

   initial begin
      reset_n = 1'b0;
      cs_n = 1'b0;
      sclk_posedge = 1'b0;
      sclk_negedge = 1'b0;
      rw_bit = 1'b0;
      exp_busy = 1'b0;
      @(negedge clk);
      step(1'b0, 1'b1, 1'b1, 1'b0, -1);
      step(1'b1, 1'b0, 1'b0, 1'b1, -1);

      do_txn(1'b1, 0, 0, 1'b0, 1'b0);   // clean read
      do_txn(1'b0, 0, 0, 1'b0, 1'b0);   // clean write
      do_txn(1'b0, 1, 6, 1'b0, 1'b0);   // cs abort after 5 address edges
      do_txn(1'b1, 0, 0, 1'b0, 1'b0);
      do_txn(1'b0, 2, 5, 1'b1, 1'b0);   // reset after 4 data edges
      do_txn(1'b0, 0, 0, 1'b0, 1'b0);
      do_txn(1'b0, 2, 8, 1'b0, 1'b0);   // cs release with 8th data edge
      do_txn(1'b0, 1, 8, 1'b0, 1'b0);   // cs release with 8th address edge
      do_txn(1'b1, 0, 0, 1'b0, 1'b1);
      do_txn(1'b0, 0, 0, 1'b0, 1'b1);

      for (int t = 0; t < 200; t++) begin
         int ph;
         ph = rb(35) ? int'($urandom_range(1, 2)) : 0;
         do_txn(rb(50), ph, int'($urandom_range(1, 8)), rb(50), 1'b1);
      end

      repeat (4) step(1'b1, 1'b0, 1'b0, 1'b1, -1);
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending events required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
